// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment loopback decoder: active-low
// segment patterns for 0..9, digit-select codes, the frame FSM states and
// the nibble that marks an undecodable digit.
package sseg_pkg;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

    localparam logic [3:0] SEL_HUNDREDS = 4'b1011;
    localparam logic [3:0] SEL_TENS     = 4'b1101;
    localparam logic [3:0] SEL_ONES     = 4'b1110;

    localparam logic [3:0] NIBBLE_INVALID = 4'hF;

    typedef enum logic [1:0] {
        SCAN,
        MUL,
        ADD
    } state_t;

endpackage

// File: rtl/sseg_to_bcd.sv
// Combinational decode of an active-low 7-segment pattern (g..a) to a BCD
// nibble; anything that is not one of the ten digit shapes is flagged.
module sseg_to_bcd
    import sseg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       invalid
);

    // Table lookup; the invalid nibble is the fallthrough for unknown shapes
    always_comb begin
        nibble  = NIBBLE_INVALID;
        invalid = 1'b0;
        case (pattern)
            SEG_0:   nibble = 4'd0;
            SEG_1:   nibble = 4'd1;
            SEG_2:   nibble = 4'd2;
            SEG_3:   nibble = 4'd3;
            SEG_4:   nibble = 4'd4;
            SEG_5:   nibble = 4'd5;
            SEG_6:   nibble = 4'd6;
            SEG_7:   nibble = 4'd7;
            SEG_8:   nibble = 4'd8;
            SEG_9:   nibble = 4'd9;
            default: invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/sseg_frame_decoder.sv
// Receive-side decoder for the multiplexed 3-digit seven-segment bus.
// Synchronizes the bus, accepts each digit once it has been stable for
// SETTLE_CYCLES samples, assembles a hundreds/tens/ones frame and converts
// it to binary. Optional stale-frame timeout: SSEG_FRAME_DECODER_TIMEOUT_EN.
module sseg_frame_decoder
    import sseg_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  sseg_in,
    input  logic [3:0]  digits_in,
    output logic [11:0] bcd,
    output logic [9:0]  value,
    output logic        valid,
    output logic        frame_err,
    output logic        stale
);

    localparam logic [15:0] ACCEPT_AT = 16'(SETTLE_CYCLES - 2);

    logic [6:0]  sseg_meta_q, sseg_meta_d, sseg_q, sseg_d, prev_sseg_q, prev_sseg_d;
    logic [3:0]  digits_meta_q, digits_meta_d, digits_q, digits_d, prev_digits_q, prev_digits_d;
    logic [15:0] cnt_q, cnt_d;
    state_t      state_q, state_d;
    logic [2:0]  mask_q, mask_d;
    logic [3:0]  hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
    logic        err_q, err_d;
    logic [9:0]  partial_q, partial_d;
    logic [11:0] bcd_q, bcd_d;
    logic [9:0]  value_q, value_d;
    logic        valid_q, valid_d, frame_err_q, frame_err_d, stale_q, stale_d;
    logic        is_digit, same_pair, accept, timeout_hit;
    logic [3:0]  nib;
    logic        nib_invalid;
    logic [9:0]  hund_w, tens_w, tens_x10;
    logic        unused_dp;

    assign unused_dp = sseg_in[7];

    sseg_to_bcd u_decode (
        .pattern (sseg_q),
        .nibble  (nib),
        .invalid (nib_invalid)
    );

    // Two-flop synchronizer plus the previous-sample copy used for stability
    always_comb begin
        sseg_meta_d   = sseg_in[6:0];
        sseg_d        = sseg_meta_q;
        prev_sseg_d   = sseg_q;
        digits_meta_d = digits_in;
        digits_d      = digits_meta_q;
        prev_digits_d = digits_q;
    end

    // Stability counter: a digit is accepted once, when it has been seen SETTLE_CYCLES times in a row
    always_comb begin
        is_digit  = (digits_q == SEL_HUNDREDS) || (digits_q == SEL_TENS) || (digits_q == SEL_ONES);
        same_pair = (digits_q == prev_digits_q) && (sseg_q == prev_sseg_q);
        cnt_d     = 16'd0;
        if (is_digit && same_pair) begin
            cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        end
        accept = is_digit && same_pair && (cnt_q == ACCEPT_AT);
    end

`ifdef SSEG_FRAME_DECODER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [IDLE_W-1:0] idle_q, idle_d;

    // Idle counter: cycles since the last acceptance, saturating at the limit
    always_comb begin
        idle_d      = idle_q;
        timeout_hit = 1'b0;
        if (accept) begin
            idle_d = '0;
        end else if (idle_q != IDLE_LIMIT) begin
            idle_d      = idle_q + IDLE_W'(1);
            timeout_hit = (idle_q == IDLE_LAST);
        end
    end

    // Idle counter register
    always_ff @(posedge clk) begin
        if (!reset) idle_q <= '0;
        else        idle_q <= idle_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    // Frame FSM: collect three digits, multiply hundreds by shift-add, then sum and publish
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        hund_d      = hund_q;
        tens_d      = tens_q;
        ones_d      = ones_q;
        err_d       = err_q;
        partial_d   = partial_q;
        bcd_d       = bcd_q;
        value_d     = value_q;
        valid_d     = 1'b0;
        frame_err_d = frame_err_q;
        stale_d     = stale_q;
        hund_w      = {6'd0, hund_q};
        tens_w      = {6'd0, tens_q};
        tens_x10    = (tens_w << 3) + (tens_w << 1);

        if (timeout_hit) begin
            mask_d  = 3'b000;
            err_d   = 1'b0;
            stale_d = 1'b1;
        end

        case (state_q)
            SCAN: begin
                if (accept) begin
                    case (digits_q)
                        SEL_HUNDREDS: begin hund_d = nib; mask_d[2] = 1'b1; end
                        SEL_TENS:     begin tens_d = nib; mask_d[1] = 1'b1; end
                        SEL_ONES:     begin ones_d = nib; mask_d[0] = 1'b1; end
                        default: ;
                    endcase
                    if (nib_invalid) err_d = 1'b1;
                    if (mask_d == 3'b111) state_d = MUL;
                end
            end
            MUL: begin
                partial_d = (hund_w << 6) + (hund_w << 5) + (hund_w << 2);
                state_d   = ADD;
            end
            ADD: begin
                bcd_d       = {hund_q, tens_q, ones_q};
                value_d     = err_q ? 10'd0 : partial_q + tens_x10 + {6'd0, ones_q};
                frame_err_d = err_q;
                valid_d     = 1'b1;
                stale_d     = 1'b0;
                mask_d      = 3'b000;
                err_d       = 1'b0;
                state_d     = SCAN;
            end
            default: state_d = SCAN;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            sseg_meta_q   <= 7'h7F;
            sseg_q        <= 7'h7F;
            prev_sseg_q   <= 7'h7F;
            digits_meta_q <= 4'hF;
            digits_q      <= 4'hF;
            prev_digits_q <= 4'hF;
            cnt_q         <= 16'd0;
            state_q       <= SCAN;
            mask_q        <= 3'b000;
            hund_q        <= 4'd0;
            tens_q        <= 4'd0;
            ones_q        <= 4'd0;
            err_q         <= 1'b0;
            partial_q     <= 10'd0;
            bcd_q         <= 12'd0;
            value_q       <= 10'd0;
            valid_q       <= 1'b0;
            frame_err_q   <= 1'b0;
            stale_q       <= 1'b0;
        end else begin
            sseg_meta_q   <= sseg_meta_d;
            sseg_q        <= sseg_d;
            prev_sseg_q   <= prev_sseg_d;
            digits_meta_q <= digits_meta_d;
            digits_q      <= digits_d;
            prev_digits_q <= prev_digits_d;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            mask_q        <= mask_d;
            hund_q        <= hund_d;
            tens_q        <= tens_d;
            ones_q        <= ones_d;
            err_q         <= err_d;
            partial_q     <= partial_d;
            bcd_q         <= bcd_d;
            value_q       <= value_d;
            valid_q       <= valid_d;
            frame_err_q   <= frame_err_d;
            stale_q       <= stale_d;
        end
    end

    assign bcd       = bcd_q;
    assign value     = value_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign stale     = stale_q;

endmodule

// File: tb/tb_sseg_frame_decoder.sv
// Self-checking bench for sseg_frame_decoder: directed frames from the
// test plan followed by randomized digit dwells, all compared against a
// dwell-level reference model of digit acceptance and frame assembly.
module tb_sseg_frame_decoder;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 200;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  sseg_in = 8'hFF;
    logic [3:0]  digits_in = 4'hF;
    logic [11:0] bcd;
    logic [9:0]  value;
    logic        valid;
    logic        frame_err;
    logic        stale;

    sseg_frame_decoder #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sseg_in   (sseg_in),
        .digits_in (digits_in),
        .bcd       (bcd),
        .value     (value),
        .valid     (valid),
        .frame_err (frame_err),
        .stale     (stale)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] bcd;
        int          value;
        bit          err;
    } frame_t;

    int          vectors = 0;
    int          miscompares = 0;
    logic [6:0]  segTable [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [3:0]  selCode [3] = '{4'b1110, 4'b1101, 4'b1011};

    // Reference model state (slot 0 = ones, 1 = tens, 2 = hundreds)
    int          mSlot [3];
    bit [2:0]    mMask;
    bit          mErr;
    int          runLen;
    logic [3:0]  lastDig;
    logic [6:0]  lastSeg;
    int          mIdle;
    bit          lastAccepted;
    frame_t      expQ [$];
    int          framesExpected = 0;
    int          framesSeen = 0;

    // Monitor state
    logic [11:0] heldBcd = 12'd0;
    int          heldValue = 0;
    bit          heldErr = 1'b0;
    bit          validPrev = 1'b0;
    frame_t      monF;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic int slotOf(input logic [3:0] d);
        for (int i = 0; i < 3; i++) if (d == selCode[i]) return i;
        return -1;
    endfunction

    function automatic int decodeSeg(input logic [6:0] p);
        for (int i = 0; i < 10; i++) if (p == segTable[i]) return i;
        return 15;
    endfunction

    task automatic modelReset();
        mMask   = 3'b000;
        mErr    = 1'b0;
        runLen  = 0;
        lastDig = 4'hF;
        lastSeg = 7'h7F;
        mIdle   = 0;
        for (int i = 0; i < 3; i++) mSlot[i] = 0;
    endtask

    // Hold one (digit, pattern) pair on the pins for a number of cycles, predicting its effect
    task automatic applyStimulus(input logic [3:0] dig, input logic [7:0] seg, input int cycles);
        int     slot;
        int     startRun;
        int     acceptAt;
        int     d;
        bit     accepts;
        frame_t f;
        slot     = slotOf(dig);
        startRun = (dig == lastDig && seg[6:0] == lastSeg) ? runLen : 0;
        accepts  = (slot >= 0) && (startRun < SETTLE) && (startRun + cycles >= SETTLE);
        acceptAt = SETTLE - 1 - startRun;
`ifdef SSEG_FRAME_DECODER_TIMEOUT_EN
        if (mIdle + (accepts ? acceptAt : cycles) >= TIMEOUT) begin
            mMask = 3'b000;
            mErr  = 1'b0;
        end
`endif
        if (accepts) begin
            d           = decodeSeg(seg[6:0]);
            mSlot[slot] = d;
            mMask[slot] = 1'b1;
            if (d == 15) mErr = 1'b1;
            if (mMask == 3'b111) begin
                f.bcd   = {mSlot[2][3:0], mSlot[1][3:0], mSlot[0][3:0]};
                f.err   = mErr;
                f.value = mErr ? 0 : mSlot[2] * 100 + mSlot[1] * 10 + mSlot[0];
                expQ.push_back(f);
                framesExpected++;
                mMask = 3'b000;
                mErr  = 1'b0;
            end
            mIdle = cycles - acceptAt;
        end else begin
            mIdle = mIdle + cycles;
        end
        lastAccepted = accepts;
        runLen  = startRun + cycles;
        lastDig = dig;
        lastSeg = seg[6:0];
        digits_in = dig;
        sseg_in   = seg;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic doReset(input int cycles);
        reset     = 1'b0;
        digits_in = 4'hF;
        sseg_in   = 8'hFF;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b1;
        modelReset();
    endtask

    // Monitor: every valid must match the next predicted frame; outputs hold otherwise
    always @(negedge clk) begin
        if (!reset) begin
            heldBcd   = 12'd0;
            heldValue = 0;
            heldErr   = 1'b0;
            validPrev = 1'b0;
        end else if (valid) begin
            checkOutput("valid_width", {31'd0, validPrev}, 32'd0);
            framesSeen++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_valid", {31'd0, valid}, 32'd0);
            end else begin
                monF = expQ.pop_front();
                checkOutput("frame_bcd", {20'd0, bcd}, {20'd0, monF.bcd});
                checkOutput("frame_value", {22'd0, value}, monF.value);
                checkOutput("frame_err", {31'd0, frame_err}, {31'd0, monF.err});
                checkOutput("stale_cleared", {31'd0, stale}, 32'd0);
                heldBcd   = monF.bcd;
                heldValue = monF.value;
                heldErr   = monF.err;
            end
            validPrev = 1'b1;
        end else begin
            checkOutput("hold_bcd", {20'd0, bcd}, {20'd0, heldBcd});
            checkOutput("hold_value", {22'd0, value}, heldValue);
            checkOutput("hold_err", {31'd0, frame_err}, {31'd0, heldErr});
            validPrev = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, frames seen %0d expected %0d", framesSeen, framesExpected);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int framesBefore;
        int nonAccept;
        int r;
        int slot;
        int cyc;
        logic [3:0] dig;
        logic [7:0] seg;

        modelReset();
        doReset(5);
        @(negedge clk);
        checkOutput("reset_bcd", {20'd0, bcd}, 32'd0);
        checkOutput("reset_value", {22'd0, value}, 32'd0);
        checkOutput("reset_valid", {31'd0, valid}, 32'd0);
        checkOutput("reset_frame_err", {31'd0, frame_err}, 32'd0);
        checkOutput("reset_stale", {31'd0, stale}, 32'd0);
        @(posedge clk); #1;

        $display("[TB] frame 359");
        applyStimulus(4'b1011, 8'hB0, 100);
        applyStimulus(4'b1101, 8'h92, 100);
        applyStimulus(4'b1110, 8'h90, 100);
        applyStimulus(4'b1111, 8'hFF, 20);
        checkOutput("f359_bcd", {20'd0, bcd}, 32'h359);
        checkOutput("f359_value", {22'd0, value}, 32'd359);
        checkOutput("f359_err", {31'd0, frame_err}, 32'd0);

        $display("[TB] frame with blank tens");
        applyStimulus(4'b1011, 8'hB0, 100);
        applyStimulus(4'b1101, 8'hFF, 100);
        applyStimulus(4'b1110, 8'h90, 100);
        applyStimulus(4'b1111, 8'hFF, 20);
        checkOutput("ferr_bcd", {20'd0, bcd}, 32'h3F9);
        checkOutput("ferr_value", {22'd0, value}, 32'd0);
        checkOutput("ferr_err", {31'd0, frame_err}, 32'd1);

        $display("[TB] short glitch rejected");
        applyStimulus(4'b1011, 8'hB0, 100);
        applyStimulus(4'b1101, 8'h92, 100);
        applyStimulus(4'b1101, 8'hF9, SETTLE - 1);
        applyStimulus(4'b1110, 8'h90, 100);
        applyStimulus(4'b1111, 8'hFF, 20);
        checkOutput("glitch_bcd", {20'd0, bcd}, 32'h359);
        checkOutput("glitch_value", {22'd0, value}, 32'd359);

        $display("[TB] out-of-order frame 670");
        applyStimulus(4'b1110, 8'hC0, 100);
        applyStimulus(4'b1011, 8'h82, 100);
        applyStimulus(4'b1101, 8'hF8, 100);
        applyStimulus(4'b1111, 8'hFF, 20);
        checkOutput("f670_bcd", {20'd0, bcd}, 32'h670);
        checkOutput("f670_value", {22'd0, value}, 32'd670);
        framesBefore = framesSeen;
        applyStimulus(4'b1111, 8'hFF, 1000);
        checkOutput("blank_no_valid", framesSeen, framesBefore);
`ifndef SSEG_FRAME_DECODER_TIMEOUT_EN
        checkOutput("stale_tied_low", {31'd0, stale}, 32'd0);
`endif

        $display("[TB] reset discards partial frame");
        applyStimulus(4'b1011, 8'hB0, 100);
        applyStimulus(4'b1101, 8'h92, 100);
        doReset(4);
        framesBefore = framesSeen;
        applyStimulus(4'b1110, 8'h90, 100);
        applyStimulus(4'b1111, 8'hFF, 50);
        checkOutput("reset_partial_no_valid", framesSeen, framesBefore);
        applyStimulus(4'b1011, 8'hB0, 100);
        applyStimulus(4'b1101, 8'h92, 100);
        applyStimulus(4'b1110, 8'h90, 100);
        applyStimulus(4'b1111, 8'hFF, 20);
        checkOutput("reset_then_frame", framesSeen, framesBefore + 1);

`ifdef SSEG_FRAME_DECODER_TIMEOUT_EN
        $display("[TB] stale timeout");
        doReset(4);
        applyStimulus(4'b1011, 8'h99, 100);
        applyStimulus(4'b1111, 8'hFF, 250);
        checkOutput("stale_set", {31'd0, stale}, 32'd1);
        applyStimulus(4'b1101, 8'hA4, 100);
        applyStimulus(4'b1110, 8'hF9, 100);
        applyStimulus(4'b1111, 8'hFF, 20);
        checkOutput("mask_cleared_no_valid", {31'd0, stale}, 32'd1);
        applyStimulus(4'b1011, 8'h92, 100);
        applyStimulus(4'b1111, 8'hFF, 20);
        checkOutput("timeout_frame_bcd", {20'd0, bcd}, 32'h521);
        checkOutput("stale_cleared_by_valid", {31'd0, stale}, 32'd0);
`endif

        $display("[TB] randomized dwells");
        doReset(4);
        nonAccept = 0;
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (nonAccept >= 3) begin
                slot = (slotOf(lastDig) + 1) % 3;
                dig  = selCode[slot];
                seg  = {1'b1, segTable[$urandom_range(0, 9)]};
                cyc  = 20;
            end else if (r < 2) begin
                case ($urandom_range(0, 3))
                    0:       dig = 4'b1111;
                    1:       dig = 4'b0111;
                    2:       dig = 4'b0011;
                    default: dig = 4'b1010;
                endcase
                seg = 8'($urandom);
                cyc = $urandom_range(1, 30);
            end else begin
                dig = selCode[$urandom_range(0, 2)];
                if ($urandom_range(0, 9) == 0) seg = 8'($urandom);
                else                           seg = {1'($urandom), segTable[$urandom_range(0, 9)]};
                cyc = ($urandom_range(0, 19) < 17) ? $urandom_range(SETTLE, 40) : $urandom_range(1, SETTLE - 1);
            end
            applyStimulus(dig, seg, cyc);
            nonAccept = lastAccepted ? 0 : nonAccept + 1;
        end
        applyStimulus(4'b1111, 8'hFF, 30);

        checkOutput("frame_count", framesSeen, framesExpected);
        checkOutput("queue_drained", expQ.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sseg_frame_decoder.md
# sseg_frame_decoder

Receive-side decoder for the multiplexed 3-digit seven-segment bus that the address display drives. It samples the active-low segment and digit-select lines, waits for each digit to settle, and decodes the segment patterns to BCD. It assembles one hundreds/tens/ones frame and converts it to a binary value. It sits on the loopback/self-test path, so the ROM reader can check what the panel actually shows against the address it intended to show.

## Interface
- SETTLE_CYCLES, 4: consecutive identical samples required before a digit is accepted (legal range 2..65535).
- TIMEOUT_CYCLES, 1000000: idle cycles without any acceptance before the frame is declared stale (only used with the timeout feature).
- clk  in  1  clock.
- reset  in  1  synchronous, active-low.
- sseg_in  in  8  segment lines, active-low; [6:0] = g..a; [7] = decimal point, ignored.
- digits_in  in  4  digit selects, active-low.
- bcd  out  12  last frame: [11:8] hundreds, [7:4] tens, [3:0] ones; 4'hF marks an undecodable digit.
- value  out  10  binary value of the last frame, 0..999; 0 when frame_err is set.
- valid  out  1  one-cycle pulse when bcd/value/frame_err update.
- frame_err  out  1  last frame contained at least one undecodable segment pattern.
- stale  out  1  no acceptance for TIMEOUT_CYCLES; cleared by the next valid.

## Operation
- Both inputs pass through a 2-flop synchronizer. All further logic uses the synchronized pair (digits, sseg).
- Digit-select codes:
  - 4'b1011 selects hundreds.
  - 4'b1101 selects tens.
  - 4'b1110 selects ones.
  - Any other code (blank 4'b1111, 4'b0111, multi-hot) is a non-digit. A non-digit clears the stability counter and is never accepted.
- Stability counter:
  - Increments while the synchronized pair equals the previous cycle's pair; resets to 0 on any change. Saturates.
  - The pair is accepted exactly once per dwell, on the cycle the counter reaches SETTLE_CYCLES-1.
- Segment decode uses sseg[6:0] and the active-low patterns for 0..9: 0x40, 0x79, 0x24, 0x30, 0x19, 0x12, 0x02, 0x78, 0x00, 0x10. Any other pattern decodes to nibble 4'hF and sets the in-frame error flag.
- State machine:
  - SCAN: on each acceptance, write the nibble into its slot and set that bit of a 3-bit capture mask. Re-accepting a slot overwrites it. Digits may arrive in any order. When the mask becomes 3'b111, go to MUL.
  - MUL: compute partial = hundreds·100 using shift-add ((h<<6)+(h<<5)+(h<<2)). Go to ADD.
  - ADD: compute value = partial + tens·10 + ones.
    - Register bcd, value and frame_err, and pulse valid.
    - If the in-frame error flag is set, value = 0 and frame_err = 1.
    - Clear the mask and error flag, then return to SCAN.
- Acceptances arriving during MUL/ADD are dropped.
- Reset at any point returns to SCAN with an empty mask. No partial frame survives reset.

## Timing
- Reset values: bcd = 0, value = 0, valid = 0, frame_err = 0, stale = 0, mask = 0, state SCAN, counters 0.
- Acceptance occurs 2 (synchronizer) + SETTLE_CYCLES - 1 clocks after a new pair appears at the pins.
- valid goes high 2 clocks after the acceptance that completes the mask (MUL, then ADD), and stays high for exactly 1 cycle.
- Outputs hold their values between valid pulses.

## Configuration
- SSEG_FRAME_DECODER_TIMEOUT_EN defined:
  - An idle counter counts cycles since the last acceptance.
  - At TIMEOUT_CYCLES it clears the mask and sets stale. stale stays set until the next valid.
  - An acceptance restarts the count.
- Not defined: no idle counter; stale is tied to 0; a partial frame waits indefinitely.

## Structure
- Shared package sseg_pkg holds:
  - the ten segment pattern constants;
  - the three digit-select codes;
  - the state enum (SCAN, MUL, ADD);
  - the nibble value 4'hF as the invalid-digit constant.
- Sub-module sseg_to_bcd: purely combinational 7-bit pattern to 4-bit nibble plus invalid flag. It is instantiated once.

## Test plan
- Hold 1011/0x30, then 1101/0x12, then 1110/0x10, each for 100 cycles. Expect one valid, bcd = 12'h359, value = 359, frame_err = 0.
- Same frame but tens pattern 0x7F (blank). Expect bcd = 12'h3F9, value = 0, frame_err = 1.
- Insert a 3-cycle glitch 1101/0x79 between digits with SETTLE_CYCLES = 4. Expect it not accepted and the frame still reads 359.
- Send ones (0x40), then hundreds (0x02), then tens (0x78) in that order. Expect bcd = 12'h670, value = 670. Then blank 1111 for 1000 cycles and expect no valid.
- Assert reset after two digits are accepted, then present only the ones digit. Expect no valid. Then present all three and expect a valid.
- With the macro defined and TIMEOUT_CYCLES = 200: send hundreds only, then idle 250 cycles. Expect stale = 1 and the mask cleared; a full later frame pulses valid and clears stale.
